seg7_pattern_receiver: RTL and testbench

//  Receiving end of the 7-segment pin-pattern interface that our art/display tiles drive (gfedcba + dp on one byte).

---
 rtl/seg7_pkg.sv | 51 +++++
 rtl/seg7_stable_filter.sv | 94 +++++++++
 rtl/seg7_pattern_receiver.sv | 76 +++++++
 tb/tb_seg7_pattern_receiver.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared 7-segment glyph definitions (gfedcba, dp excluded) and the glyph-to-hex decoder.
// Also used by the display drivers, so keep the encodings in sync with them.
package seg7_pkg;

    typedef enum logic [1:0] {IDLE, SETTLING, LOCKED} seg7_state_t;

    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_0 = 7'h3F;
    localparam logic [6:0] SEG_1 = 7'h06;
    localparam logic [6:0] SEG_2 = 7'h5B;
    localparam logic [6:0] SEG_3 = 7'h4F;
    localparam logic [6:0] SEG_4 = 7'h66;
    localparam logic [6:0] SEG_5 = 7'h6D;
    localparam logic [6:0] SEG_6 = 7'h7D;
    localparam logic [6:0] SEG_7 = 7'h07;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h6F;
    localparam logic [6:0] SEG_A = 7'h77;
    localparam logic [6:0] SEG_B = 7'h7C;
    localparam logic [6:0] SEG_C = 7'h39;
    localparam logic [6:0] SEG_D = 7'h5E;
    localparam logic [6:0] SEG_E = 7'h79;
    localparam logic [6:0] SEG_F = 7'h71;

    // Returns {err, nibble}; unknown patterns decode to err=1, nibble=0.
    function automatic logic [4:0] seg7_to_hex(input logic [6:0] seg);
        logic [4:0] res;
        res = 5'h10;
        case (seg)
            SEG_0: res = 5'h00;
            SEG_1: res = 5'h01;
            SEG_2: res = 5'h02;
            SEG_3: res = 5'h03;
            SEG_4: res = 5'h04;
            SEG_5: res = 5'h05;
            SEG_6: res = 5'h06;
            SEG_7: res = 5'h07;
            SEG_8: res = 5'h08;
            SEG_9: res = 5'h09;
            SEG_A: res = 5'h0A;
            SEG_B: res = 5'h0B;
            SEG_C: res = 5'h0C;
            SEG_D: res = 5'h0D;
            SEG_E: res = 5'h0E;
            SEG_F: res = 5'h0F;
            default: res = 5'h10;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/seg7_stable_filter.sv
// Glitch filter for the segment bus: a new pattern must be sampled on STABLE_CYCLES+1
// consecutive edges before a single-cycle accept is raised for it.
module seg7_stable_filter
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] seg_in,
    output logic       accept,
    output logic [7:0] pattern
);

    localparam logic [7:0] LAST_CNT = 8'(STABLE_CYCLES - 1);

    seg7_state_t state_reg, state_next;
    logic [7:0]  sample_reg;
    logic [7:0]  cnt_reg, cnt_next;
    logic [7:0]  last_reg, last_next;
    logic        last_valid_reg, last_valid_next;

    logic blank, same, repeat_last, window_done;

    assign blank       = (seg_in[6:0] == SEG_BLANK);
    assign same        = (seg_in == sample_reg);
    assign repeat_last = last_valid_reg && (seg_in == last_reg);
    assign window_done = same && (cnt_reg == LAST_CNT);
    assign pattern     = seg_in;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            sample_reg     <= 8'h00;
            cnt_reg        <= 8'h00;
            last_reg       <= 8'h00;
            last_valid_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            sample_reg     <= seg_in;
            cnt_reg        <= cnt_next;
            last_reg       <= last_next;
            last_valid_reg <= last_valid_next;
        end
    end

    // cnt_reg counts matching edges after the first sighting of the pattern.
    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        last_next       = last_reg;
        last_valid_next = last_valid_reg;
        if (blank) begin
            state_next      = IDLE;
            cnt_next        = 8'h00;
            last_valid_next = 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    state_next = SETTLING;
                    cnt_next   = 8'h00;
                end
                SETTLING: begin
                    if (!same) begin
                        cnt_next = 8'h00;
                    end else if (window_done) begin
                        state_next      = LOCKED;
                        last_next       = seg_in;
                        last_valid_next = 1'b1;
                    end else begin
                        cnt_next = cnt_reg + 8'h01;
                    end
                end
                LOCKED: begin
                    if (!same) begin
                        state_next = SETTLING;
                        cnt_next   = 8'h00;
                    end
                end
                default: begin
                    state_next = IDLE;
                    cnt_next   = 8'h00;
                end
            endcase
        end
    end

    always_comb begin
        accept = 1'b0;
        if (state_reg == SETTLING && !blank && window_done && !repeat_last)
            accept = 1'b1;
    end

endmodule

// File: rtl/seg7_pattern_receiver.sv
// Segment-bus receiver: filters the bus, decodes accepted glyphs to hex and offers
// them on a one-entry valid/ready output register with overflow flag and delivery count.
module seg7_pattern_receiver
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int COUNT_W       = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         seg_in,
    output logic               sym_valid,
    input  logic               sym_ready,
    output logic [3:0]         sym_data,
    output logic               sym_dp,
    output logic               sym_err,
    output logic               overflow,
    output logic [COUNT_W-1:0] sym_count
);

    logic       accept;
    logic [7:0] pattern;
    logic [4:0] decoded;

    logic               sym_valid_reg;
    logic [3:0]         sym_data_reg;
    logic               sym_dp_reg;
    logic               sym_err_reg;
    logic               overflow_reg;
    logic [COUNT_W-1:0] sym_count_reg;

    seg7_stable_filter #(
        .STABLE_CYCLES(STABLE_CYCLES)
    ) u_filter (
        .clk    (clk),
        .rst    (rst),
        .seg_in (seg_in),
        .accept (accept),
        .pattern(pattern)
    );

    assign decoded = seg7_to_hex(pattern[6:0]);

    always_ff @(posedge clk) begin
        if (rst) begin
            sym_valid_reg <= 1'b0;
            sym_data_reg  <= 4'h0;
            sym_dp_reg    <= 1'b0;
            sym_err_reg   <= 1'b0;
            overflow_reg  <= 1'b0;
            sym_count_reg <= '0;
        end else if (accept) begin
            // The register frees up on the same edge it transfers, so a
            // simultaneous accept is loaded rather than dropped.
            if (!sym_valid_reg || sym_ready) begin
                sym_valid_reg <= 1'b1;
                sym_data_reg  <= decoded[3:0];
                sym_err_reg   <= decoded[4];
                sym_dp_reg    <= pattern[7];
                sym_count_reg <= sym_count_reg + 1'b1;
            end else begin
                overflow_reg <= 1'b1;
            end
        end else if (sym_valid_reg && sym_ready) begin
            sym_valid_reg <= 1'b0;
        end
    end

    assign sym_valid = sym_valid_reg;
    assign sym_data  = sym_data_reg;
    assign sym_dp    = sym_dp_reg;
    assign sym_err   = sym_err_reg;
    assign overflow  = overflow_reg;
    assign sym_count = sym_count_reg;

endmodule

// File: tb/tb_seg7_pattern_receiver.sv
// Bench for seg7_pattern_receiver: scenario tasks with inline checks plus a scoreboard
// of expected {dp, err, data} symbols popped whenever a transfer is observed.
module tb_seg7_pattern_receiver;

    logic       clk;
    logic       rst;
    logic [7:0] seg_in;
    logic       sym_valid;
    logic       sym_ready;
    logic [3:0] sym_data;
    logic       sym_dp;
    logic       sym_err;
    logic       overflow;
    logic [7:0] sym_count;

    int total;
    int bad;
    logic [5:0] exp_q[$];

    seg7_pattern_receiver #(
        .STABLE_CYCLES(4),
        .COUNT_W(8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .seg_in   (seg_in),
        .sym_valid(sym_valid),
        .sym_ready(sym_ready),
        .sym_data (sym_data),
        .sym_dp   (sym_dp),
        .sym_err  (sym_err),
        .overflow (overflow),
        .sym_count(sym_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs only change 1 time unit after a rising edge, so values seen at the
    // falling edge are the ones the next rising edge will act on.
    always @(negedge clk) begin
        if (!rst && sym_valid && sym_ready) begin
            logic [5:0] exp_sym;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL transfer_unexpected: got dp=%0b err=%0b data=%h, no symbol expected",
                         sym_dp, sym_err, sym_data);
            end else begin
                exp_sym = exp_q.pop_front();
                if ({sym_dp, sym_err, sym_data} !== exp_sym) begin
                    bad++;
                    $display("FAIL transfer_data: got dp/err/data=%b, expected %b",
                             {sym_dp, sym_err, sym_data}, exp_sym);
                end else begin
                    $display("transfer ok: dp=%0b err=%0b data=%h", sym_dp, sym_err, sym_data);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] p, input int n);
        seg_in = p;
        step(n);
    endtask

    task automatic check_zero(input string name);
        total++;
        if ({sym_valid, sym_data, sym_dp, sym_err, overflow, sym_count} !== 16'h0000) begin
            bad++;
            $display("FAIL %s: valid=%0b data=%h dp=%0b err=%0b ovf=%0b count=%0d, expected all zero",
                     name, sym_valid, sym_data, sym_dp, sym_err, overflow, sym_count);
        end
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        step(1);
        exp_q.delete();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        seg_in = 8'h00;
        sym_ready = 1'b0;
        step(3);
        check_zero("reset_state");
        rst = 1'b0;
        $display("test_reset done");
    endtask

    task automatic test_first_symbol();
        sym_ready = 1'b0;
        seg_in = 8'h6F;
        exp_q.push_back({1'b0, 1'b0, 4'h9});
        for (int i = 0; i < 4; i++) begin
            step(1);
            total++;
            if (sym_valid !== 1'b0) begin
                bad++;
                $display("FAIL first_early_valid: edge %0d valid=%0b, expected 0", i, sym_valid);
            end
        end
        step(1);
        total++;
        if ({sym_valid, sym_data, sym_dp, sym_err, sym_count} !== {1'b1, 4'h9, 1'b0, 1'b0, 8'd1}) begin
            bad++;
            $display("FAIL first_accept: valid=%0b data=%h dp=%0b err=%0b count=%0d, expected 1 9 0 0 1",
                     sym_valid, sym_data, sym_dp, sym_err, sym_count);
        end
        sym_ready = 1'b1;
        step(1);
        total++;
        if (sym_valid !== 1'b0) begin
            bad++;
            $display("FAIL first_drop_valid: valid=%0b, expected 0", sym_valid);
        end
        drive(8'h00, 2);
        $display("test_first_symbol done");
    endtask

    task automatic test_glitch_and_hold();
        int highs;
        logic [7:0] base;
        sym_ready = 1'b1;
        seg_in = 8'h39;
        for (int i = 0; i < 5; i++) begin
            if (i == 3) seg_in = 8'h00;
            step(1);
            total++;
            if (sym_valid !== 1'b0) begin
                bad++;
                $display("FAIL short_pulse_valid: edge %0d valid=%0b, expected 0", i, sym_valid);
            end
        end
        base = sym_count;
        highs = 0;
        exp_q.push_back({1'b0, 1'b0, 4'hC});
        seg_in = 8'h39;
        for (int i = 0; i < 10; i++) begin
            step(1);
            if (sym_valid) highs++;
        end
        total++;
        if (highs != 1 || sym_count !== base + 8'd1) begin
            bad++;
            $display("FAIL hold_single: valid cycles=%0d count delta=%0d, expected 1 and 1",
                     highs, sym_count - base);
        end
        drive(8'h00, 2);
        $display("test_glitch_and_hold done");
    endtask

    task automatic test_repeat_rules();
        logic [7:0] base;
        sym_ready = 1'b1;
        base = sym_count;
        exp_q.push_back({1'b0, 1'b0, 4'h9});
        drive(8'h6F, 6);
        drive(8'h00, 6);
        exp_q.push_back({1'b0, 1'b0, 4'h9});
        drive(8'h6F, 6);
        drive(8'h6F, 6);
        exp_q.push_back({1'b1, 1'b0, 4'h9});
        drive(8'hEF, 6);
        drive(8'h00, 6);
        total++;
        if (sym_count !== base + 8'd3 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL repeat_rules: count delta=%0d pending=%0d, expected 3 and 0",
                     sym_count - base, exp_q.size());
        end
        $display("test_repeat_rules done");
    endtask

    task automatic test_bad_glyph();
        logic [7:0] base;
        sym_ready = 1'b0;
        base = sym_count;
        exp_q.push_back({1'b0, 1'b1, 4'h0});
        drive(8'h55, 6);
        total++;
        if ({sym_valid, sym_err, sym_data} !== {1'b1, 1'b1, 4'h0} || sym_count !== base + 8'd1) begin
            bad++;
            $display("FAIL bad_glyph: valid=%0b err=%0b data=%h count delta=%0d, expected 1 1 0 1",
                     sym_valid, sym_err, sym_data, sym_count - base);
        end
        sym_ready = 1'b1;
        drive(8'h00, 2);
        $display("test_bad_glyph done");
    endtask

    task automatic test_overflow();
        sym_ready = 1'b0;
        pulse_reset();
        exp_q.push_back({1'b0, 1'b0, 4'h1});
        drive(8'h06, 6);
        drive(8'h5B, 6);
        total++;
        if ({sym_valid, sym_data, overflow, sym_count} !== {1'b1, 4'h1, 1'b1, 8'd1}) begin
            bad++;
            $display("FAIL overflow_hold: valid=%0b data=%h ovf=%0b count=%0d, expected 1 1 1 1",
                     sym_valid, sym_data, overflow, sym_count);
        end
        sym_ready = 1'b1;
        step(1);
        total++;
        if (sym_valid !== 1'b0 || overflow !== 1'b1) begin
            bad++;
            $display("FAIL overflow_release: valid=%0b ovf=%0b, expected 0 1", sym_valid, overflow);
        end
        drive(8'h00, 3);
        total++;
        if (overflow !== 1'b1) begin
            bad++;
            $display("FAIL overflow_sticky: ovf=%0b, expected 1", overflow);
        end
        $display("test_overflow done");
    endtask

    task automatic reaccept_after_reset(input string name);
        exp_q.push_back({1'b0, 1'b0, 4'h8});
        for (int i = 0; i < 4; i++) begin
            step(1);
            total++;
            if (sym_valid !== 1'b0) begin
                bad++;
                $display("FAIL %s_early: edge %0d valid=%0b, expected 0", name, i, sym_valid);
            end
        end
        step(1);
        total++;
        if ({sym_valid, sym_data, sym_count} !== {1'b1, 4'h8, 8'd1}) begin
            bad++;
            $display("FAIL %s_accept: valid=%0b data=%h count=%0d, expected 1 8 1",
                     name, sym_valid, sym_data, sym_count);
        end
    endtask

    task automatic test_reset_midway();
        sym_ready = 1'b0;
        drive(8'h7F, 2);
        pulse_reset();
        check_zero("reset_mid_settling");
        reaccept_after_reset("reaccept1");
        pulse_reset();
        check_zero("reset_mid_handshake");
        reaccept_after_reset("reaccept2");
        sym_ready = 1'b1;
        step(1);
        drive(8'h00, 2);
        $display("test_reset_midway done");
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst = 1'b1;
        seg_in = 8'h00;
        sym_ready = 1'b0;
        test_reset();
        test_first_symbol();
        test_glitch_and_hold();
        test_repeat_rules();
        test_bad_glyph();
        test_overflow();
        test_reset_midway();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: %0d symbols never delivered, expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
